// File: rtl/calc_seq_pkg.sv
// calc_seq_pkg: shared states, widths and word packing for calc_operand_sequencer
package calc_seq_pkg;
  localparam int DW = 3;
  localparam int OPW = 2;
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_HOLD = 3'd4
  } state_t;
  function automatic logic [2*DW+OPW-1:0] pack_calc_word(
    input logic [OPW-1:0] op,
    input logic [DW-1:0]  b,
    input logic [DW-1:0]  a
  );
    return {op, b, a};
  endfunction
endpackage

// File: rtl/calc_seq_sync.sv
// calc_seq_sync: 2-flop strobe synchroniser with one-cycle rising-edge pulse
module calc_seq_sync (
  input  logic clk,
  input  logic rst,
  input  logic in_stb,
  output logic stb_pulse
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {s1, s2, s3} <= 3'b000;
    else     {s1, s2, s3} <= {in_stb, s1, s2};
  end
  assign stb_pulse = s2 & ~s3;
endmodule

// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: strobed A/B/opcode entry, calculator drive and held result (CALC_SEQ_ACC_EN enables accumulator feedback)
module calc_operand_sequencer
  import calc_seq_pkg::*;
#(
  parameter int DW       = calc_seq_pkg::DW,
  parameter int OPW      = calc_seq_pkg::OPW,
  parameter int EXEC_CYC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_stb,
  output logic       in_ready,
  output logic [7:0] calc_in,
  input  logic [7:0] calc_out,
  output logic [7:0] res_data,
  output logic       res_valid,
  input  logic       res_ack,
  output logic [2:0] state_o
);
  state_t         state;
  logic [DW-1:0]  a, b;
  logic [OPW-1:0] op;
  logic [2:0]     cnt;
  logic           stb;
  logic           unused_bits;
  calc_seq_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .in_stb    (in_stb),
    .stb_pulse (stb)
  );
  assign calc_in     = pack_calc_word(op, b, a);
  assign state_o     = state;
  assign unused_bits = ^in_data[7:DW];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_A;
      a         <= '0;
      b         <= '0;
      op        <= '0;
      cnt       <= '0;
      res_data  <= 8'h00;
      res_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_A: if (stb) begin
          a     <= in_data[DW-1:0];
          state <= S_B;
        end
        S_B: if (stb) begin
          b     <= in_data[DW-1:0];
          state <= S_OP;
        end
        S_OP: if (stb) begin
          op       <= in_data[OPW-1:0];
          cnt      <= 3'(EXEC_CYC);
          in_ready <= 1'b0;
          state    <= S_EXEC;
        end
        S_EXEC: if (cnt == 3'd1) begin
          res_data  <= calc_out;
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end else begin
          cnt <= cnt - 3'd1;
        end
        S_HOLD: if (res_ack) begin
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
`ifdef CALC_SEQ_ACC_EN
          a         <= res_data[DW-1:0];
          state     <= S_B;
`else
          state     <= S_A;
`endif
        end
        default: begin
          state     <= S_A;
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_operand_sequencer.sv
// tb_calc_operand_sequencer: scoreboarded random/directed bench with calc_out = calc_in ^ 8'hA5
module tb_calc_operand_sequencer;
  localparam int EXEC_CYC = 1;
`ifdef CALC_SEQ_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_stb = 1'b0;
  logic       res_ack = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, res_valid;
  logic [7:0] calc_in, calc_out, res_data;
  logic [2:0] state_o;
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         entry_cyc = 0;
  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;
  bit         have_a = 1'b0;
  int         a_m = 0;
  calc_operand_sequencer #(.DW(3), .OPW(2), .EXEC_CYC(EXEC_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_stb    (in_stb),
    .in_ready  (in_ready),
    .calc_in   (calc_in),
    .calc_out  (calc_out),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ack   (res_ack),
    .state_o   (state_o)
  );
  assign calc_out = calc_in ^ 8'hA5;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] word(input int op, input int b, input int a);
    return 8'((op % 4) * 64 + (b % 8) * 8 + (a % 8));
  endfunction
  always @(negedge clk) begin
    if (res_valid === 1'b1 && prev_v !== 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_result", {24'd0, res_data}, 32'hFFFF_FFFF);
      else begin
        check("res_data", {24'd0, res_data}, {24'd0, exp_q.pop_front()});
        check("latency", cyc - entry_cyc, EXEC_CYC);
      end
    end
    prev_v = res_valid;
  end
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    in_data = d;
    in_stb = 1'b1;
    repeat (3) @(posedge clk);
    #1 entry_cyc = cyc;
    @(negedge clk);
    in_stb = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic ack();
    @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 20 && res_valid !== 1'b1; i++) @(negedge clk);
    check("valid_timeout", res_valid, 1);
  endtask
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_state", state_o, 0);
    check("rst_calc_in", calc_in, 0);
    @(negedge clk);
    rst = 1'b0;
    have_a = 1'b0;
  endtask
  task automatic run_seq();
    int b, op, nd;
    logic [7:0] w;
    if (!have_a) begin
      a_m = $urandom_range(0, 255);
      strobe(8'(a_m));
      a_m = a_m % 8;
    end
    if ($urandom_range(0, 1) == 1) begin
      ack();
      check("ack_ignored", state_o, 1);
    end
    b = $urandom_range(0, 255);
    strobe(8'(b));
    op = $urandom_range(0, 255);
    w = word(op, b, a_m);
    exp_q.push_back(w ^ 8'hA5);
    strobe(8'(op));
    wait_valid();
    check("calc_in", calc_in, w);
    nd = $urandom_range(0, 2);
    repeat (nd) strobe(8'($urandom_range(0, 255)));
    check("drop_calc_in", calc_in, w);
    check("drop_res", res_data, w ^ 8'hA5);
    check("drop_ready", in_ready, 0);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    ack();
    check("post_ack_state", state_o, ACC ? 1 : 0);
    check("post_ack_valid", res_valid, 0);
    check("post_ack_res", res_data, w ^ 8'hA5);
    have_a = ACC;
    a_m = (w ^ 8'hA5) % 8;
  endtask
  initial begin
    #3 rst = 1'b1;
    #1 check("t1_state", state_o, 0);
    check("t1_ready", in_ready, 1);
    check("t1_calc_in", calc_in, 0);
    check("t1_res_data", res_data, 0);
    check("t1_res_valid", res_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    strobe(8'h05);
    check("t2_state_b", state_o, 1);
    strobe(8'h03);
    check("t2_state_op", state_o, 2);
    check("t2_calc_in_ab", calc_in, 8'h1D);
    exp_q.push_back(8'h38);
    strobe(8'h02);
    wait_valid();
    check("t2_calc_in", calc_in, 8'h9D);
    check("t2_state_hold", state_o, 4);
    check("t2_ready", in_ready, 0);
    strobe(8'h07);
    strobe(8'h07);
    check("t3_calc_in", calc_in, 8'h9D);
    check("t3_res", res_data, 8'h38);
    check("t3_valid", res_valid, 1);
    check("t3_state", state_o, 4);
    ack();
    check("t2_ack_state", state_o, ACC ? 1 : 0);
    check("t2_ack_valid", res_valid, 0);
    check("t2_ack_res", res_data, 8'h38);
    if (ACC) begin
      check("t6_calc_a", calc_in[2:0], 0);
      exp_q.push_back(8'hAD);
      strobe(8'h01);
      strobe(8'h00);
      wait_valid();
      check("t6_calc_in", calc_in, 8'h08);
      ack();
      check("t6_state", state_o, 1);
    end
    pulse_reset();
    @(negedge clk);
    in_data = 8'h01;
    in_stb = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_state", state_o, 1);
    check("t4_a", calc_in[2:0], 1);
    in_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_state_after", state_o, 1);
    strobe(8'h06);
    check("t5_pre_state", state_o, 2);
    pulse_reset();
    check("t5_ready", in_ready, 1);
    run_seq();
    for (int i = 0; i < 25; i++) run_seq();
    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
